// File: rtl/filtros_pkg.sv
// Shared definitions for the filter front-end.
// Holds the default RAM geometry (ADDR_W, IN_BASE, OUT_BASE), the byte type
// pixel_t and the loader FSM state enum loader_state_t.
package filtros_pkg;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] IN_BASE  = 32'h0000_0000;
  localparam logic [31:0] OUT_BASE = 32'h0001_0000;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_OUT
  } loader_state_t;

endpackage

// File: rtl/image_loader_ram_port_mux.sv
// ram_port_mux: combinational owner-select for the physical RAM port.
// sel_proc=1 (loader in RUN) : ram_* follows proc_*, proc_rdata = ram_rdata.
// sel_proc=0                 : ram_* follows the loader's registered port,
//                              proc_rdata = 0 and proc_* requests are dropped.
// Ports: ld_* (loader port in), proc_* (processor port), ram_* (physical RAM).
module ram_port_mux #(
  parameter int ADDR_W = 32
) (
  input  logic              sel_proc,
  input  logic              ld_re,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  input  logic              proc_re,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_wdata,
  output logic [7:0]        proc_rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  import filtros_pkg::*;

  always_comb begin
    if (sel_proc) begin
      ram_re     = proc_re;
      ram_we     = proc_we;
      ram_addr   = proc_addr;
      ram_wdata  = proc_wdata;
      proc_rdata = pixel_t'(ram_rdata);
    end else begin
      ram_re     = ld_re;
      ram_we     = ld_we;
      ram_addr   = ld_addr;
      ram_wdata  = ld_wdata;
      proc_rdata = '0;
    end
  end

endmodule

// File: rtl/image_loader.sv
// image_loader: owns the image RAM port around a filter run.
//   LOAD : streams cmd_len bytes from s_* into RAM at IN_BASE (1 byte/cycle).
//   RUN  : pulses proc_start, hands the RAM port to proc_* until proc_done.
//   DUMP : reads cmd_len bytes from OUT_BASE and emits them on m_* (1 per 3+ cycles).
// Ports: clk/rst_n (async low), cmd_start/cmd_len/busy/job_done (control),
//        s_* (input stream), m_* (result stream), proc_* (processor RAM port
//        and start/done handshake), ram_* (physical RAM, 1-cycle read latency),
//        checksum (16-bit sum of loaded bytes).
// Build option: define IMAGE_LOADER_CHECKSUM_EN to enable the checksum
// accumulator; otherwise checksum is tied to zero.
module image_loader #(
  parameter int                ADDR_W   = filtros_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(filtros_pkg::IN_BASE),
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(filtros_pkg::OUT_BASE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic              busy,
  output logic              job_done,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              proc_start,
  input  logic              proc_done,
  input  logic              proc_re,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_wdata,
  output logic [7:0]        proc_rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [15:0]       checksum
);
  import filtros_pkg::*;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ld_re_q, ld_re_d;
  logic              ld_we_q, ld_we_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  pixel_t            ld_wdata_q, ld_wdata_d;
  pixel_t            m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              proc_start_q, proc_start_d;
  logic              job_done_q, job_done_d;

  logic s_hs, m_hs, last_out, load_full;

  // In LOAD, cnt counts accepted bytes; once it reaches len the last write
  // is still in flight on the registered port, so LOAD lasts one more cycle
  // with s_ready low before the port is handed over.
  assign load_full = (cnt_q == len_q);
  assign s_ready   = (state_q == LOAD) && !load_full;
  assign s_hs      = s_ready && s_valid;
  assign m_hs      = (state_q == DUMP_OUT) && m_valid_q && m_ready;
  assign last_out  = (cnt_q == len_q - ADDR_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_start) state_d = (cmd_len == '0) ? RUN : LOAD;
      LOAD:      if (load_full) state_d = RUN;
      RUN:       if (proc_done) state_d = (len_q == '0) ? IDLE : DUMP_RD;
      DUMP_RD:   state_d = DUMP_WAIT;
      DUMP_WAIT: state_d = DUMP_OUT;
      DUMP_OUT:  if (m_hs) state_d = last_out ? IDLE : DUMP_RD;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    busy       = (state_q != IDLE);
    len_d      = len_q;
    cnt_d      = cnt_q;
    ld_we_d    = 1'b0;
    ld_addr_d  = ld_addr_q;
    ld_wdata_d = ld_wdata_q;
    m_data_d   = m_data_q;

    if (state_q == IDLE && cmd_start) begin
      len_d = cmd_len;
      cnt_d = '0;
    end
    if (s_hs) begin
      ld_we_d    = 1'b1;
      ld_addr_d  = IN_BASE + cnt_q;
      ld_wdata_d = pixel_t'(s_data);
      cnt_d      = cnt_q + ADDR_W'(1);
    end
    if (state_q == RUN && proc_done) cnt_d = '0;
    if (m_hs)                        cnt_d = cnt_q + ADDR_W'(1);
    if (state_q == DUMP_WAIT)        m_data_d = pixel_t'(ram_rdata);

    // Read request is registered so it is presented for the whole DUMP_RD
    // cycle; data returns in DUMP_WAIT.
    ld_re_d = (state_d == DUMP_RD);
    if (ld_re_d) ld_addr_d = OUT_BASE + cnt_d;

    m_valid_d    = (state_d == DUMP_OUT);
    proc_start_d = (state_d == RUN) && (state_q != RUN);
    job_done_d   = (state_d == IDLE) && (state_q == RUN || state_q == DUMP_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      cnt_q        <= '0;
      ld_re_q      <= 1'b0;
      ld_we_q      <= 1'b0;
      ld_addr_q    <= '0;
      ld_wdata_q   <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      proc_start_q <= 1'b0;
      job_done_q   <= 1'b0;
    end else begin
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      ld_re_q      <= ld_re_d;
      ld_we_q      <= ld_we_d;
      ld_addr_q    <= ld_addr_d;
      ld_wdata_q   <= ld_wdata_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      proc_start_q <= proc_start_d;
      job_done_q   <= job_done_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign proc_start = proc_start_q;
  assign job_done   = job_done_q;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && cmd_start) sum_d = '0;
    else if (s_hs)                    sum_d = sum_q + 16'(s_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

  ram_port_mux #(.ADDR_W(ADDR_W)) u_mux (
    .sel_proc   (state_q == RUN),
    .ld_re      (ld_re_q),
    .ld_we      (ld_we_q),
    .ld_addr    (ld_addr_q),
    .ld_wdata   (ld_wdata_q),
    .proc_re    (proc_re),
    .proc_we    (proc_we),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

endmodule

// File: tb/tb_image_loader.sv
// Testbench for image_loader: behavioural RAM with 1-cycle read latency,
// scoreboard queues for RAM writes and result bytes, one task per scenario.
module tb_image_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_len = '0;
  logic        busy, job_done;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        proc_start;
  logic        proc_done = 1'b0;
  logic        proc_re = 1'b0, proc_we = 1'b0;
  logic [31:0] proc_addr = '0;
  logic [7:0]  proc_wdata = '0;
  logic [7:0]  proc_rdata;
  logic        ram_re, ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  image_loader dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .busy(busy), .job_done(job_done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .proc_start(proc_start), .proc_done(proc_done),
    .proc_re(proc_re), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .checksum(checksum)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [7:0]  exp_px[$];
  logic [7:0]  mem [0:511];
  int unsigned cyc = 0;
  int          n_ps = 0, n_jd = 0;
  int          vectors = 0, miscompares = 0;

  localparam logic [15:0] SUM_LOAD4 =
`ifdef IMAGE_LOADER_CHECKSUM_EN
    16'h00AA;
`else
    16'h0000;
`endif
  localparam logic [15:0] SUM_RST2 =
`ifdef IMAGE_LOADER_CHECKSUM_EN
    16'h00FF;
`else
    16'h0000;
`endif

  // Tests only touch 0x00..0xFF and 0x10000..0x100FF.
  function automatic int midx(input logic [31:0] a);
    return int'(a[16]) * 256 + int'(a[7:0]);
  endfunction

  // RAM model + write log + pulse counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[midx(ram_addr)] <= ram_wdata;
      obs_q.push_back('{cyc, ram_addr, ram_wdata});
    end
    if (ram_re) ram_rdata <= mem[midx(ram_addr)];
    if (proc_start) n_ps <= n_ps + 1;
    if (job_done)   n_jd <= n_jd + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    vectors++;
    if ({busy, job_done, s_ready, m_valid, proc_start, ram_re, ram_we} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {busy, job_done, s_ready, m_valid, proc_start, ram_re, ram_we});
    end
    vectors++;
    if (m_data !== 8'h00 || proc_rdata !== 8'h00 || ram_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: m_data=%h proc_rdata=%h ram_wdata=%h want 00", m_data, proc_rdata, ram_wdata);
    end
    vectors++;
    if (ram_addr !== 32'h0 || checksum !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_addr_sum: addr=%h sum=%h want 0", ram_addr, checksum);
    end
    rst_n = 1'b1;
    tick;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_load_run;
    wr_t e, o;
    int  ps0;
    obs_q.delete(); exp_q.delete();
    ps0 = n_ps;
    cmd_start = 1'b1; cmd_len = 32'd4;
    tick;
    cmd_start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b want 1", busy); end
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'h11 * (i + 1));
      vectors++;
      if (s_ready !== 1'b1) begin miscompares++; $display("FAIL load_ready[%0d]: got %b want 1", i, s_ready); end
      exp_q.push_back('{cyc + 1, 32'(i), s_data});
      tick;
    end
    s_valid = 1'b0;
    vectors++;
    if (s_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 32'd3 || proc_start !== 1'b0) begin
      miscompares++;
      $display("FAIL final_write_cycle: ready=%b we=%b addr=%h pstart=%b want 0 1 3 0", s_ready, ram_we, ram_addr, proc_start);
    end
    tick;
    vectors++;
    if (proc_start !== 1'b1) begin miscompares++; $display("FAIL proc_start_pulse: got %b want 1", proc_start); end
    tick;
    vectors++;
    if (proc_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL proc_start_end: pstart=%b busy=%b want 0 1", proc_start, busy);
    end
    vectors++;
    if (obs_q.size() != 4) begin miscompares++; $display("FAIL load_wr_count: got %0d want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
        miscompares++;
        $display("FAIL load_wr: got cyc%0d @%h=%h want cyc%0d @%h=%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
      end
    end
    vectors++;
    if (checksum !== SUM_LOAD4) begin miscompares++; $display("FAIL load_checksum: got %h want %h", checksum, SUM_LOAD4); end
    vectors++;
    if (n_ps - ps0 != 1) begin miscompares++; $display("FAIL proc_start_count: got %0d want 1", n_ps - ps0); end
  endtask

  task automatic test_run_passthrough;
    proc_we = 1'b1; proc_addr = 32'h20; proc_wdata = 8'h5A;
    #1;
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== 32'h20 || ram_wdata !== 8'h5A) begin
      miscompares++;
      $display("FAIL pass_wr: we=%b addr=%h data=%h want 1 20 5a", ram_we, ram_addr, ram_wdata);
    end
    tick;
    proc_we = 1'b0; proc_re = 1'b1;
    #1;
    vectors++;
    if (ram_re !== 1'b1 || ram_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL pass_rd: re=%b addr=%h want 1 20", ram_re, ram_addr);
    end
    tick;
    proc_re = 1'b0;
    vectors++;
    if (proc_rdata !== 8'h5A) begin miscompares++; $display("FAIL pass_rdata: got %h want 5a", proc_rdata); end
    // processor deposits its results at OUT_BASE
    for (int i = 0; i < 4; i++) begin
      proc_we = 1'b1; proc_addr = 32'h0001_0000 + 32'(i); proc_wdata = 8'(8'hA0 + i);
      exp_px.push_back(proc_wdata);
      tick;
    end
    proc_we = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_ignored_cmd;
    int ps0;
    ps0 = n_ps;
    cmd_start = 1'b1; cmd_len = 32'd9;
    tick;
    cmd_start = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b1 || s_ready !== 1'b0 || proc_start !== 1'b0 || n_ps != ps0) begin
      miscompares++;
      $display("FAIL ignored_cmd_start: busy=%b ready=%b pstart=%b n=%0d want 1 0 0 0", busy, s_ready, proc_start, n_ps - ps0);
    end
  endtask

  task automatic test_dump_backpressure;
    logic [7:0] want, held;
    int idx, hold, t, jd0;
    jd0 = n_jd;
    proc_done = 1'b1;
    tick;
    proc_done = 1'b0;
    vectors++;
    if (ram_re !== 1'b1 || ram_addr !== 32'h0001_0000 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_rd: re=%b addr=%h mv=%b want 1 10000 0", ram_re, ram_addr, m_valid);
    end
    t = 0;
    while (!m_valid && t < 10) begin tick; t++; end
    vectors++;
    if (t != 2) begin miscompares++; $display("FAIL mvalid_latency: got %0d want 2", t); end
    idx = 0; hold = 0; t = 0; held = '0;
    while (idx < 4 && t < 200) begin
      m_ready = 1'b0;
      if (m_valid) begin
        if (idx == 1 && hold < 5) begin
          if (hold > 0) begin
            vectors++;
            if (m_data !== held) begin miscompares++; $display("FAIL hold_stable: got %h want %h", m_data, held); end
          end
          held = m_data;
          hold++;
        end else begin
          want = exp_px.pop_front();
          vectors++;
          if (m_data !== want) begin miscompares++; $display("FAIL dump_byte[%0d]: got %h want %h", idx, m_data, want); end
          m_ready = 1'b1;
          idx++;
        end
      end
      tick;
      t++;
    end
    m_ready = 1'b0;
    vectors++;
    if (idx != 4) begin miscompares++; $display("FAIL dump_timeout: got %0d bytes want 4", idx); end
    vectors++;
    if (job_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_job_done: jd=%b busy=%b want 1 0", job_done, busy);
    end
    tick; tick;
    vectors++;
    if (job_done !== 1'b0 || n_jd - jd0 != 1) begin
      miscompares++;
      $display("FAIL job_done_pulse: jd=%b n=%0d want 0 1", job_done, n_jd - jd0);
    end
  endtask

  task automatic test_zero_len;
    int  ps0, jd0;
    logic saw_mv;
    ps0 = n_ps; jd0 = n_jd;
    obs_q.delete();
    cmd_start = 1'b1; cmd_len = 32'd0;
    tick;
    cmd_start = 1'b0;
    vectors++;
    if (proc_start !== 1'b1) begin miscompares++; $display("FAIL zero_pstart: got %b want 1", proc_start); end
    vectors++;
    if (checksum !== 16'h0) begin miscompares++; $display("FAIL checksum_clear: got %h want 0000", checksum); end
    proc_done = 1'b1;  // same cycle as proc_start
    tick;
    proc_done = 1'b0;
    vectors++;
    if (job_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_job_done: jd=%b busy=%b want 1 0", job_done, busy);
    end
    saw_mv = m_valid;
    repeat (3) begin tick; saw_mv |= m_valid; end
    vectors++;
    if (saw_mv !== 1'b0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_no_traffic: mv=%b writes=%0d want 0 0", saw_mv, obs_q.size());
    end
    vectors++;
    if (n_ps - ps0 != 1 || n_jd - jd0 != 1) begin
      miscompares++;
      $display("FAIL zero_pulses: ps=%0d jd=%0d want 1 1", n_ps - ps0, n_jd - jd0);
    end
  endtask

  task automatic test_reset_mid_job;
    wr_t e, o;
    int  ps0, jd0;
    cmd_start = 1'b1; cmd_len = 32'd8;
    tick;
    cmd_start = 1'b0;
    s_valid = 1'b1; s_data = 8'hC1;
    tick;
    s_data = 8'hC2;
    tick;
    s_valid = 1'b0;
    ps0 = n_ps; jd0 = n_jd;
    proc_done = 1'b1;  // must be ignored in LOAD
    tick;
    proc_done = 1'b0;
    vectors++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || proc_start !== 1'b0 || job_done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_proc_done: busy=%b ready=%b ps=%b jd=%b want 1 1 0 0", busy, s_ready, proc_start, job_done);
    end
    tick;
    vectors++;
    if (n_ps != ps0 || n_jd != jd0) begin
      miscompares++;
      $display("FAIL ignored_pulses: ps=%0d jd=%0d want 0 0", n_ps - ps0, n_jd - jd0);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, job_done, s_ready, m_valid, proc_start, ram_re, ram_we} !== 7'b0 ||
        ram_addr !== 32'h0 || ram_wdata !== 8'h0 || m_data !== 8'h0 ||
        proc_rdata !== 8'h0 || checksum !== 16'h0) begin
      miscompares++;
      $display("FAIL midjob_reset: ctl=%b addr=%h wd=%h md=%h pr=%h sum=%h want all 0",
               {busy, job_done, s_ready, m_valid, proc_start, ram_re, ram_we},
               ram_addr, ram_wdata, m_data, proc_rdata, checksum);
    end
    tick;
    rst_n = 1'b1;
    tick;
    obs_q.delete(); exp_q.delete();
    cmd_start = 1'b1; cmd_len = 32'd2;
    tick;
    cmd_start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data = 8'(8'h77 + 8'h11 * i);
      exp_q.push_back('{cyc + 1, 32'(i), s_data});
      tick;
    end
    s_valid = 1'b0;
    tick; tick;
    vectors++;
    if (obs_q.size() != 2) begin miscompares++; $display("FAIL restart_wr_count: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++;
      if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
        miscompares++;
        $display("FAIL restart_wr: got cyc%0d @%h=%h want cyc%0d @%h=%h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
      end
    end
    vectors++;
    if (checksum !== SUM_RST2) begin miscompares++; $display("FAIL restart_checksum: got %h want %h", checksum, SUM_RST2); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_run_passthrough();
    test_ignored_cmd();
    test_dump_backpressure();
    test_zero_len();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

endmodule
